// File: rtl/pitch_frame_scheduler.sv
// rtl/pitch_frame_scheduler.sv - circular-buffer frame sequencer in front of the min-tau pitch analyzer
module pitch_frame_scheduler #(
   parameter int DATA_WIDTH       = 8,
   parameter int WINDOW_SIZE_BITS = 8,
   parameter int MAX_TAU          = 40,
   parameter int HOP              = 128,
   parameter int TIMEOUT_CYCLES   = 4096
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [DATA_WIDTH-1:0]       sample_in,
   input  logic                        sample_valid,
   output logic                        mem_wr_en,
   output logic [WINDOW_SIZE_BITS:0]   mem_wr_addr,
   output logic [DATA_WIDTH-1:0]       mem_wr_data,
   output logic [WINDOW_SIZE_BITS:0]   frame_base,
   output logic                        an_reset,
   input  logic                        an_ready,
   input  logic [7:0]                  an_min_tau,
   output logic [7:0]                  pitch_tau,
   output logic                        pitch_valid,
   output logic                        timeout,
   output logic                        overrun
);

   // Buffer holds two windows; pointers carry one extra bit so that
   // "completely full" and "empty" are distinguishable.
   localparam int AW          = WINDOW_SIZE_BITS + 1;
   localparam int PW          = AW + 1;
   localparam int BUFFER_SIZE = 1 << AW;
   localparam int FRAME_LEN   = (1 << WINDOW_SIZE_BITS) + MAX_TAU;
   localparam int CW          = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [PW-1:0] BUF_FULL  = PW'(BUFFER_SIZE);
   localparam logic [PW-1:0] FRAME_MIN = PW'(FRAME_LEN);
   localparam logic [PW-1:0] HOP_STEP  = PW'(HOP);
   localparam logic [PW-1:0] PTR_ONE   = PW'(1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   // Sequencer states
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ARM  = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]      state_q,       state_d;
   logic [PW-1:0]   wr_ptr_q,      wr_ptr_d;
   logic [PW-1:0]   rd_base_q,     rd_base_d;
   logic [CW-1:0]   cnt_q,         cnt_d;
   logic [7:0]      pitch_tau_q,   pitch_tau_d;
   logic            pitch_valid_q, pitch_valid_d;
   logic            timeout_q,     timeout_d;
   logic            overrun_q,     overrun_d;

   logic [PW-1:0]   avail;
   logic            full;
   logic            wr_fire;
   logic            frame_ready;
   logic            run_abort;

   // Occupancy: wraps naturally, range 0..BUFFER_SIZE.
   assign avail       = wr_ptr_q - rd_base_q;
   assign full        = (avail == BUF_FULL);
   assign wr_fire     = sample_valid & ~full;
   assign frame_ready = (avail >= FRAME_MIN);
   assign run_abort   = (cnt_q == CNT_LAST);

   assign mem_wr_en   = wr_fire;
   assign mem_wr_addr = wr_ptr_q[AW-1:0];
   assign mem_wr_data = sample_in;
   assign frame_base  = rd_base_q[AW-1:0];

   // The analyzer is only released while the frame is actually running.
   assign an_reset    = (state_q != ST_RUN);

   assign pitch_tau   = pitch_tau_q;
   assign pitch_valid = pitch_valid_q;
   assign timeout     = timeout_q;
   assign overrun     = overrun_q;

   // Next-state: sample writer runs independently of the frame sequencer.
   always_comb begin
      state_d       = state_q;
      wr_ptr_d      = wr_ptr_q;
      rd_base_d     = rd_base_q;
      cnt_d         = cnt_q;
      pitch_tau_d   = pitch_tau_q;
      pitch_valid_d = 1'b0;
      timeout_d     = timeout_q;
      overrun_d     = overrun_q;

      // A full buffer drops the sample rather than clobbering a frame in flight.
      if (wr_fire) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (sample_valid && full) begin
         overrun_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (enable && frame_ready) begin
               state_d = ST_ARM;
            end
         end
         ST_ARM: begin
            cnt_d   = '0;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            cnt_d = cnt_q + CNT_ONE;
            // an_ready takes precedence over the watchdog on the same cycle.
            // Result and frame advance are registered so they appear together
            // with pitch_valid in DONE.
            if (an_ready) begin
               state_d       = ST_DONE;
               pitch_tau_d   = an_min_tau;
               pitch_valid_d = 1'b1;
               rd_base_d     = rd_base_q + HOP_STEP;
            end else if (run_abort) begin
               state_d       = ST_DONE;
               pitch_tau_d   = 8'd0;
               pitch_valid_d = 1'b1;
               timeout_d     = 1'b1;
               rd_base_d     = rd_base_q + HOP_STEP;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         wr_ptr_q      <= '0;
         rd_base_q     <= '0;
         cnt_q         <= '0;
         pitch_tau_q   <= 8'd0;
         pitch_valid_q <= 1'b0;
         timeout_q     <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_base_q     <= rd_base_d;
         cnt_q         <= cnt_d;
         pitch_tau_q   <= pitch_tau_d;
         pitch_valid_q <= pitch_valid_d;
         timeout_q     <= timeout_d;
         overrun_q     <= overrun_d;
      end
   end

endmodule
